// File: rtl/alu_slice_pkg.sv
// Shared constants and function-code encodings for the alu_slice32 datapath.
package alu_slice_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        FUN_ADD = 2'b00,
        FUN_SUB = 2'b01,
        FUN_AND = 2'b10,
        FUN_XOR = 2'b11
    } fun_e;

endpackage

// File: rtl/alu_slice32_if.sv
// Operand/result bus for alu_slice32. Flag signals exist only when ALU_SLICE_FLAGS_EN is defined.
interface alu_slice32_if
    import alu_slice_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
);

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    fun_e             fun;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             out_valid;
`ifdef ALU_SLICE_FLAGS_EN
    logic             zf;
    logic             sf;
    logic             of;
`endif

`ifdef ALU_SLICE_FLAGS_EN
    modport master (
        output in_valid, a, b, cin, fun,
        input  result, cout, out_valid, zf, sf, of
    );

    modport slave (
        input  in_valid, a, b, cin, fun,
        output result, cout, out_valid, zf, sf, of
    );
`else
    modport master (
        output in_valid, a, b, cin, fun,
        input  result, cout, out_valid
    );

    modport slave (
        input  in_valid, a, b, cin, fun,
        output result, cout, out_valid
    );
`endif

endinterface

// File: rtl/full_adder_bit.sv
// One-bit full adder cell used as a link of the ripple-carry chain.
module full_adder_bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum and carry of a single bit position
    always_comb begin
        s  = x ^ y ^ ci;
        co = (x & y) | (ci & (x ^ y));
    end

endmodule

// File: rtl/alu_slice32.sv
// Registered 32-bit ALU slice: ADD, SUB (b - a), AND, XOR with 1-cycle latency.
// Optional macro ALU_SLICE_FLAGS_EN adds registered zf/sf/of flag outputs.
module alu_slice32
    import alu_slice_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_slice32_if.slave  bus
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] x_op;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] result_c;
    logic             cout_c;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             out_valid_q;

    // Subtraction inverts operand A; cin supplies the +1 (or the lower slice's carry)
    always_comb begin
        x_op     = (bus.fun == FUN_SUB) ? ~bus.a : bus.a;
        carry[0] = bus.cin;
    end

    // Ripple-carry chain of single-bit full adders
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ripple
        full_adder_bit u_fa (
            .x  (x_op[i]),
            .y  (bus.b[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    // Four-way result mux; logic ops never produce a carry
    always_comb begin
        result_c = '0;
        cout_c   = 1'b0;
        case (bus.fun)
            FUN_ADD, FUN_SUB: begin
                result_c = sum;
                cout_c   = carry[WIDTH];
            end
            FUN_AND: result_c = bus.a & bus.b;
            FUN_XOR: result_c = bus.a ^ bus.b;
            default: result_c = '0;
        endcase
    end

    // Output registers: capture on in_valid, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                result_q <= result_c;
                cout_q   <= cout_c;
            end
        end
    end

    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.out_valid = out_valid_q;

`ifdef ALU_SLICE_FLAGS_EN
    logic zf_c;
    logic sf_c;
    logic of_c;
    logic zf_q;
    logic sf_q;
    logic of_q;

    // Flags derived from the result about to be registered
    always_comb begin
        zf_c = (result_c == '0);
        sf_c = result_c[WIDTH-1];
        of_c = 1'b0;
        if (bus.fun == FUN_ADD || bus.fun == FUN_SUB) begin
            of_c = carry[WIDTH-1] ^ carry[WIDTH];
        end
    end

    // Flag registers follow the same capture/hold rule as result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf_q <= 1'b0;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else if (bus.in_valid) begin
            zf_q <= zf_c;
            sf_q <= sf_c;
            of_q <= of_c;
        end
    end

    assign bus.zf = zf_q;
    assign bus.sf = sf_q;
    assign bus.of = of_q;
`endif

endmodule

// File: tb/tb_alu_slice32.sv
// Directed self-checking bench for alu_slice32 (flag checks when ALU_SLICE_FLAGS_EN is defined).
module tb_alu_slice32;
    import alu_slice_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    alu_slice32_if bus ();

    alu_slice32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one valid operation and wait until just after the capturing edge
    task automatic apply(input fun_e f, input logic [31:0] a, input logic [31:0] b, input logic cin);
        bus.in_valid = 1'b1;
        bus.fun      = f;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.fun      = FUN_ADD;
        bus.a        = '0;
        bus.b        = '0;
        bus.cin      = 1'b0;
        #3;
        n_tests++;
        if (bus.result !== 32'h0 || bus.cout !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_initial: result=%h cout=%b vld=%b, expected 0/0/0", bus.result, bus.cout, bus.out_valid);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(negedge clk);
        // Produce a nonzero state, then reset mid-run without a clock edge
        apply(FUN_ADD, 32'h0000_1234, 32'h0000_0001, 1'b1);
        n_tests++;
        if (bus.result !== 32'h0000_1236 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_op: result=%h vld=%b, expected 00001236/1", bus.result, bus.out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.result !== 32'h0 || bus.cout !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: result=%h cout=%b vld=%b, expected 0/0/0", bus.result, bus.cout, bus.out_valid);
        end
        // Valid input pending while reset is held must not be captured
        bus.in_valid = 1'b1;
        bus.fun      = FUN_XOR;
        bus.a        = 32'hDEAD_BEEF;
        bus.b        = 32'h0;
        @(posedge clk); #1;
        n_tests++;
        if (bus.result !== 32'h0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wins: result=%h vld=%b, expected 0/0", bus.result, bus.out_valid);
        end
        #2;
        rst_n = 1'b1;
        #2;
        // First valid after release is captured normally
        apply(FUN_XOR, 32'hDEAD_BEEF, 32'h0000_FFFF, 1'b0);
        n_tests++;
        if (bus.result !== 32'hDEAD_4110 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_valid: result=%h vld=%b, expected dead4110/1", bus.result, bus.out_valid);
        end
    endtask

    task automatic test_add();
        apply(FUN_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        n_tests++;
        if (bus.result !== 32'h0 || bus.cout !== 1'b1 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL add_wrap: result=%h cout=%b vld=%b, expected 00000000/1/1", bus.result, bus.cout, bus.out_valid);
        end
        apply(FUN_ADD, 32'h1234_5678, 32'h1111_1111, 1'b1);
        n_tests++;
        if (bus.result !== 32'h2345_678A || bus.cout !== 1'b0) begin
            n_fail++;
            $display("FAIL add_cin: result=%h cout=%b, expected 2345678a/0", bus.result, bus.cout);
        end
    endtask

    task automatic test_sub();
        apply(FUN_SUB, 32'd5, 32'd12, 1'b1);
        n_tests++;
        if (bus.result !== 32'h0000_0007 || bus.cout !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_pos: result=%h cout=%b, expected 00000007/1", bus.result, bus.cout);
        end
        apply(FUN_SUB, 32'd12, 32'd5, 1'b1);
        n_tests++;
        if (bus.result !== 32'hFFFF_FFF9 || bus.cout !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_neg: result=%h cout=%b, expected fffffff9/0", bus.result, bus.cout);
        end
    endtask

    task automatic test_logic();
        apply(FUN_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
        n_tests++;
        if (bus.result !== 32'hF000_F000 || bus.cout !== 1'b0) begin
            n_fail++;
            $display("FAIL and: result=%h cout=%b, expected f000f000/0", bus.result, bus.cout);
        end
        apply(FUN_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
        n_tests++;
        if (bus.result !== 32'h0FF0_0FF0 || bus.cout !== 1'b0) begin
            n_fail++;
            $display("FAIL xor: result=%h cout=%b, expected 0ff00ff0/0", bus.result, bus.cout);
        end
    endtask

    task automatic test_hold();
        apply(FUN_ADD, 32'h0000_0010, 32'h0000_0020, 1'b0);
        bus.in_valid = 1'b0;
        bus.fun      = FUN_SUB;
        bus.a        = 32'hFFFF_FFFF;
        bus.b        = 32'h0000_0001;
        bus.cin      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (bus.result !== 32'h0000_0030 || bus.cout !== 1'b0 || bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d: result=%h cout=%b vld=%b, expected 00000030/0/0", i, bus.result, bus.cout, bus.out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        apply(FUN_ADD, 32'h0000_0001, 32'h0000_0002, 1'b0);
        n_tests++;
        if (bus.result !== 32'h0000_0003 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_add: result=%h vld=%b, expected 00000003/1", bus.result, bus.out_valid);
        end
        apply(FUN_SUB, 32'h0000_0001, 32'h0000_0000, 1'b1);
        n_tests++;
        if (bus.result !== 32'hFFFF_FFFF || bus.cout !== 1'b0 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_sub: result=%h cout=%b vld=%b, expected ffffffff/0/1", bus.result, bus.cout, bus.out_valid);
        end
        // 64-bit add 0x1_FFFFFFFF + 1 built from two slice operations
        apply(FUN_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        n_tests++;
        if (bus.result !== 32'h0 || bus.cout !== 1'b1) begin
            n_fail++;
            $display("FAIL chain_lo: result=%h cout=%b, expected 00000000/1", bus.result, bus.cout);
        end
        apply(FUN_ADD, 32'h0000_0001, 32'h0000_0000, bus.cout);
        n_tests++;
        if (bus.result !== 32'h0000_0002 || bus.cout !== 1'b0) begin
            n_fail++;
            $display("FAIL chain_hi: result=%h cout=%b, expected 00000002/0", bus.result, bus.cout);
        end
    endtask

`ifdef ALU_SLICE_FLAGS_EN
    task automatic test_flags();
        apply(FUN_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        n_tests++;
        if (bus.result !== 32'h8000_0000 || bus.of !== 1'b1 || bus.sf !== 1'b1 || bus.zf !== 1'b0) begin
            n_fail++;
            $display("FAIL flags_ovf: result=%h of=%b sf=%b zf=%b, expected 80000000/1/1/0", bus.result, bus.of, bus.sf, bus.zf);
        end
        apply(FUN_SUB, 32'd7, 32'd7, 1'b1);
        n_tests++;
        if (bus.result !== 32'h0 || bus.zf !== 1'b1 || bus.of !== 1'b0 || bus.cout !== 1'b1 || bus.sf !== 1'b0) begin
            n_fail++;
            $display("FAIL flags_zero: result=%h zf=%b of=%b cout=%b sf=%b, expected 0/1/0/1/0", bus.result, bus.zf, bus.of, bus.cout, bus.sf);
        end
        bus.in_valid = 1'b0;
        bus.fun      = FUN_AND;
        bus.a        = 32'h8000_0000;
        bus.b        = 32'h8000_0000;
        @(posedge clk); #1;
        n_tests++;
        if (bus.zf !== 1'b1 || bus.sf !== 1'b0 || bus.of !== 1'b0) begin
            n_fail++;
            $display("FAIL flags_hold: zf=%b sf=%b of=%b, expected 1/0/0", bus.zf, bus.sf, bus.of);
        end
        apply(FUN_AND, 32'h8000_0000, 32'h8000_0000, 1'b1);
        n_tests++;
        if (bus.zf !== 1'b0 || bus.sf !== 1'b1 || bus.of !== 1'b0) begin
            n_fail++;
            $display("FAIL flags_logic: zf=%b sf=%b of=%b, expected 0/1/0", bus.zf, bus.sf, bus.of);
        end
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_hold();
        test_back_to_back();
`ifdef ALU_SLICE_FLAGS_EN
        test_flags();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
